// File: rtl/transmisor_mdio.sv
// transmisor_mdio: Clause-22 MDIO station management controller.
// Serialises a 32-bit frame word MSB-first, with an optional preamble of
// ones. MDC runs at CLK/2 during a frame. For read opcodes the line is
// released from the turnaround onward and 16 data bits are captured.
module transmisor_mdio #(
  parameter int PREAMBLE_BITS = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    FRAME = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Last preamble bit index; only meaningful when a preamble exists.
  localparam logic [5:0] PRE_LAST  = (PREAMBLE_BITS > 0) ? 6'(PREAMBLE_BITS - 1) : 6'd0;
  localparam logic [5:0] FRM_LAST  = 6'd31;
  localparam logic [5:0] TA_FIRST  = 6'd14;
  localparam logic [5:0] DAT_FIRST = 6'd16;

  state_t      state, state_nx;
  logic [31:0] shreg;     // frame bits, current bit always at [31]
  logic        is_read;   // latched opcode decode (OP == 2'b10)
  logic [5:0]  cnt;       // bit index inside PRE or FRAME
  logic        phase;     // 0: MDC low half, 1: MDC high half
  logic [14:0] rd_shift;  // read bits 16..30; bit 31 goes straight to RD_DATA

  logic pre_end, frm_end, rd_sample;

  assign pre_end   = (state == PRE)   && phase && (cnt == PRE_LAST);
  assign frm_end   = (state == FRAME) && phase && (cnt == FRM_LAST);
  assign rd_sample = (state == FRAME) && phase && is_read && (cnt >= DAT_FIRST);

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (MDIO_START) state_nx = (PREAMBLE_BITS > 0) ? PRE : FRAME;
      PRE:     if (pre_end)    state_nx = FRAME;
      FRAME:   if (frm_end)    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: frame latch/shift, bit and phase counters, read capture.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      shreg    <= '0;
      is_read  <= 1'b0;
      cnt      <= '0;
      phase    <= 1'b0;
      rd_shift <= '0;
      RD_DATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          phase <= 1'b0;
          if (MDIO_START) begin
            shreg   <= T_DATA;
            is_read <= (T_DATA[29:28] == 2'b10);
          end
        end
        PRE: begin
          phase <= ~phase;
          if (phase) cnt <= pre_end ? 6'd0 : cnt + 6'd1;
        end
        FRAME: begin
          phase <= ~phase;
          if (phase) begin
            // Counter holds at the last bit instead of wrapping.
            if (!frm_end) cnt <= cnt + 6'd1;
            shreg <= {shreg[30:0], 1'b0};
          end
          if (rd_sample) begin
            if (frm_end) RD_DATA  <= {rd_shift, MDIO_IN};
            else         rd_shift <= {rd_shift[13:0], MDIO_IN};
          end
        end
        DONE: begin
          cnt   <= '0;
          phase <= 1'b0;
        end
        default: begin
          cnt   <= '0;
          phase <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only, so they change right
  // at the edge that enters each phase and stay stable across MDC rising.
  always_comb begin
    MDC      = 1'b0;
    MDIO_OUT = 1'b0;
    MDIO_OE  = 1'b0;
    BUSY     = 1'b0;
    DATA_RDY = 1'b0;
    case (state)
      PRE: begin
        MDC      = phase;
        MDIO_OUT = 1'b1;
        MDIO_OE  = 1'b1;
        BUSY     = 1'b1;
      end
      FRAME: begin
        MDC  = phase;
        BUSY = 1'b1;
        // Reads release the line from TA onward; output forced low there.
        MDIO_OE  = !(is_read && (cnt >= TA_FIRST));
        MDIO_OUT = MDIO_OE && shreg[31];
      end
      DONE:    DATA_RDY = is_read;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_transmisor_mdio.sv
// Directed bench for transmisor_mdio: one instance without preamble, one
// with a 32-bit preamble, sharing the clock and reset.
module tb_transmisor_mdio;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [31:0] tdata_a, tdata_b;
  logic        mdin_a, mdin_b;
  logic        mdc_a, out_a, oe_a, rdy_a, busy_a;
  logic        mdc_b, out_b, oe_b, rdy_b, busy_b;
  logic [15:0] rd_a, rd_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd = 16'h0000;

  always #5 CLK = ~CLK;

  transmisor_mdio #(.PREAMBLE_BITS(0)) dut_a (
    .CLK(CLK), .reset(reset), .MDIO_START(start_a), .T_DATA(tdata_a),
    .MDIO_IN(mdin_a), .MDC(mdc_a), .MDIO_OUT(out_a), .MDIO_OE(oe_a),
    .RD_DATA(rd_a), .DATA_RDY(rdy_a), .BUSY(busy_a)
  );

  transmisor_mdio #(.PREAMBLE_BITS(32)) dut_b (
    .CLK(CLK), .reset(reset), .MDIO_START(start_b), .T_DATA(tdata_b),
    .MDIO_IN(mdin_b), .MDC(mdc_b), .MDIO_OUT(out_b), .MDIO_OE(oe_b),
    .RD_DATA(rd_b), .DATA_RDY(rdy_b), .BUSY(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " mdc"},  {31'd0, mdc_a},  32'd0);
    chk({tag, " oe"},   {31'd0, oe_a},   32'd0);
    chk({tag, " out"},  {31'd0, out_a},  32'd0);
    chk({tag, " busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, " rdy"},  {31'd0, rdy_a},  32'd0);
    chk({tag, " rd"},   {16'd0, rd_a},   {16'd0, exp_rd});
  endtask

  // Runs one frame on dut_a, called just after an edge in IDLE.
  // phy: data the PHY model returns on reads. inject_at: cycle after which
  // a second START is raised (-1 none). abort_at: edge offset at which
  // reset is sampled low (-1 none).
  task automatic frame_a(input string tag, input logic [31:0] word,
                         input logic [15:0] phy, input int inject_at,
                         input int abort_at);
    logic rd;
    int   i;
    logic ph, e_oe, e_out;
    rd = (word[29:28] == 2'b10);
    tdata_a = word;
    start_a = 1'b1;
    step();                         // edge E0
    start_a = 1'b0;
    tdata_a = ~word;                // later T_DATA changes must be ignored
    for (int c = 0; c < 64; c++) begin
      i  = c / 2;
      ph = c[0];
      e_oe  = rd ? (i < 14) : 1'b1;
      e_out = e_oe ? word[31 - i] : 1'b0;
      chk($sformatf("%s c%0d mdc", tag, c),  {31'd0, mdc_a},  {31'd0, ph});
      chk($sformatf("%s c%0d out", tag, c),  {31'd0, out_a},  {31'd0, e_out});
      chk($sformatf("%s c%0d oe", tag, c),   {31'd0, oe_a},   {31'd0, e_oe});
      chk($sformatf("%s c%0d busy", tag, c), {31'd0, busy_a}, 32'd1);
      chk($sformatf("%s c%0d rdy", tag, c),  {31'd0, rdy_a},  32'd0);
      // Outside the data phase the PHY drives 1 so stray sampling shows up.
      mdin_a = (i >= 16) ? phy[31 - i] : 1'b1;
      if (c == inject_at) begin
        start_a = 1'b1;
        tdata_a = 32'h6252_0000;
      end else begin
        start_a = 1'b0;
      end
      if (c + 1 == abort_at) reset = 1'b0;
      step();
      if (c + 1 == abort_at) begin
        exp_rd = 16'h0000;
        chk_idle_a({tag, " abort"});
        return;
      end
    end
    // E0+64: DONE
    if (rd) exp_rd = phy;
    chk({tag, " done busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, " done mdc"},  {31'd0, mdc_a},  32'd0);
    chk({tag, " done oe"},   {31'd0, oe_a},   32'd0);
    chk({tag, " done out"},  {31'd0, out_a},  32'd0);
    chk({tag, " done rdy"},  {31'd0, rdy_a},  {31'd0, rd});
    chk({tag, " done rd"},   {16'd0, rd_a},   {16'd0, exp_rd});
    mdin_a = 1'b0;
    step();
    chk_idle_a({tag, " after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    tdata_a = 32'h5252_5555;
    tdata_b = 32'h5252_5555;
    mdin_a  = 1'b0;
    mdin_b  = 1'b0;

    // 1: reset held with START high -> nothing starts
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle_a($sformatf("reset%0d", k));
      chk($sformatf("reset%0d busy_b", k), {31'd0, busy_b}, 32'd0);
      chk($sformatf("reset%0d oe_b", k),   {31'd0, oe_b},   32'd0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    reset   = 1'b1;
    step();
    chk_idle_a("post_reset");

    // 2: plain write
    frame_a("write", 32'h5252_5555, 16'h0000, -1, -1);

    // 3: read, PHY returns A5A5
    frame_a("read", 32'h6252_0000, 16'hA5A5, -1, -1);

    // 4: START during write ignored; RD_DATA keeps A5A5
    frame_a("busyrej", 32'h5252_5555, 16'h0000, 9, -1);

    // 5: reset at E0+40 of a read, then a fresh read
    frame_a("abort", 32'h6252_0000, 16'hA5A5, -1, 40);
    reset = 1'b1;
    step();
    chk_idle_a("abort_idle");
    frame_a("reread", 32'h6252_0000, 16'h3C96, -1, -1);

    // back-to-back: next frame accepted on the first IDLE cycle
    frame_a("b2b", 32'h5012_ABCD, 16'h0000, -1, -1);

    // 6: 32-bit preamble build, write
    tdata_b = 32'h5252_5555;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    tdata_b = 32'h0000_0000;
    for (int c = 0; c < 128; c++) begin
      automatic int   i  = c / 2;
      automatic logic eo = (i < 32) ? 1'b1 : tdata_exp_b(i - 32);
      chk($sformatf("pre c%0d mdc", c),  {31'd0, mdc_b},  {31'd0, c[0]});
      chk($sformatf("pre c%0d out", c),  {31'd0, out_b},  {31'd0, eo});
      chk($sformatf("pre c%0d oe", c),   {31'd0, oe_b},   32'd1);
      chk($sformatf("pre c%0d busy", c), {31'd0, busy_b}, 32'd1);
      step();
    end
    chk("pre done busy", {31'd0, busy_b}, 32'd0);
    chk("pre done oe",   {31'd0, oe_b},   32'd0);
    chk("pre done rdy",  {31'd0, rdy_b},  32'd0);
    chk("pre done rd",   {16'd0, rd_b},   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic tdata_exp_b(input int i);
    logic [31:0] w;
    w = 32'h5252_5555;
    return w[31 - i];
  endfunction

endmodule
